// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: requester-side and I2C-master-side signals of the request arbiter.
interface i2c_req_arbiter_if #(parameter int NUM_REQ = 4);
   logic [NUM_REQ-1:0]   req_valid;
   logic [7*NUM_REQ-1:0] req_addr;
   logic [NUM_REQ-1:0]   req_rw;
   logic [8*NUM_REQ-1:0] req_wdata;
   logic [NUM_REQ-1:0]   req_grant;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [7:0]           rsp_rdata;
   logic                 rsp_nack;
   logic                 rsp_timeout;
   logic                 m_start;
   logic [6:0]           m_addr;
   logic                 m_rw;
   logic [7:0]           m_wdata;
   logic                 m_ready;
   logic                 m_done;
   logic                 m_nack;
   logic [7:0]           m_rdata;
   logic                 m_abort;
   modport slave (
      input  req_valid, req_addr, req_rw, req_wdata, m_ready, m_done, m_nack, m_rdata,
      output req_grant, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, m_start, m_addr, m_rw,
             m_wdata, m_abort
   );
   modport master (
      output req_valid, req_addr, req_rw, req_wdata, m_ready, m_done, m_nack, m_rdata,
      input  req_grant, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, m_start, m_addr, m_rw,
             m_wdata, m_abort
   );
endinterface

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one I2C master engine between NUM_REQ requesters,
// with command latching, start/ready handshake, completion watchdog and enforced bus free time.
module i2c_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int TIMEOUT    = 4096,
   parameter int GAP_CYCLES = 5
) (
   input logic              clk,
   input logic              n_rst,
   i2c_req_arbiter_if.slave bus_io
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      rr_q, rr_d, win_q, win_d, pick;
   logic [NUM_REQ-1:0] grant_q, grant_d, rsp_valid_q, rsp_valid_d;
   logic [6:0]         addr_q, addr_d;
   logic               rw_q, rw_d;
   logic [7:0]         wdata_q, wdata_d, rdata_q, rdata_d;
   logic               start_q, start_d, nack_q, nack_d, tmo_q, tmo_d, abort_q, abort_d;
   logic [WW-1:0]      wd_q, wd_d;
   logic [GW-1:0]      gap_q, gap_d;

   // Search downward from the farthest candidate so the nearest one after rr_q wins.
   always_comb begin
      pick = rr_q;
      for (int k = NUM_REQ; k >= 1; k--)
         if (bus_io.req_valid[(int'(rr_q) + k) % NUM_REQ]) pick = PW'((int'(rr_q) + k) % NUM_REQ);
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      win_d       = win_q;
      grant_d     = '0;
      rsp_valid_d = '0;
      addr_d      = addr_q;
      rw_d        = rw_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      start_d     = start_q;
      nack_d      = nack_q;
      tmo_d       = tmo_q;
      abort_d     = 1'b0;
      wd_d        = wd_q;
      gap_d       = gap_q;
      case (state_q)
         IDLE: if (|bus_io.req_valid) begin
            win_d   = pick;
            rr_d    = pick;
            addr_d  = bus_io.req_addr[int'(pick)*7 +: 7];
            rw_d    = bus_io.req_rw[pick];
            wdata_d = bus_io.req_wdata[int'(pick)*8 +: 8];
            grant_d = NUM_REQ'(1) << pick;
            start_d = 1'b1;
            state_d = ISSUE;
         end
         ISSUE: if (bus_io.m_ready) begin
            start_d = 1'b0;
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            wd_d = wd_q + WW'(1);
            if (bus_io.m_done) begin
               rdata_d     = bus_io.m_rdata;
               nack_d      = bus_io.m_nack;
               tmo_d       = 1'b0;
               rsp_valid_d = NUM_REQ'(1) << win_q;
               state_d     = RESP;
            end else if (TIMEOUT != 0 && wd_q == WW'(TIMEOUT - 1)) begin
               rdata_d     = '0;
               nack_d      = 1'b0;
               tmo_d       = 1'b1;
               abort_d     = 1'b1;
               rsp_valid_d = NUM_REQ'(1) << win_q;
               state_d     = RESP;
            end
         end
         RESP: begin
            gap_d   = '0;
            state_d = GAP_CYCLES == 0 ? IDLE : GAP;
         end
         GAP: begin
            gap_d = gap_q + GW'(1);
            if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         rr_q        <= PW'(NUM_REQ - 1);
         win_q       <= '0;
         grant_q     <= '0;
         rsp_valid_q <= '0;
         addr_q      <= '0;
         rw_q        <= 1'b0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         start_q     <= 1'b0;
         nack_q      <= 1'b0;
         tmo_q       <= 1'b0;
         abort_q     <= 1'b0;
         wd_q        <= '0;
         gap_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         win_q       <= win_d;
         grant_q     <= grant_d;
         rsp_valid_q <= rsp_valid_d;
         addr_q      <= addr_d;
         rw_q        <= rw_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         start_q     <= start_d;
         nack_q      <= nack_d;
         tmo_q       <= tmo_d;
         abort_q     <= abort_d;
         wd_q        <= wd_d;
         gap_q       <= gap_d;
      end
   end

   assign bus_io.req_grant   = grant_q;
   assign bus_io.rsp_valid   = rsp_valid_q;
   assign bus_io.rsp_rdata   = rdata_q;
   assign bus_io.rsp_nack    = nack_q;
   assign bus_io.rsp_timeout = tmo_q;
   assign bus_io.m_start     = start_q;
   assign bus_io.m_addr      = addr_q;
   assign bus_io.m_rw        = rw_q;
   assign bus_io.m_wdata     = wdata_q;
   assign bus_io.m_abort     = abort_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: vector table plus hand sequences; grants and responses are
// predicted into queues at stimulus time and compared when the arbiter emits them.
module tb_i2c_req_arbiter;
   localparam int N = 4;

   typedef struct {
      logic [N-1:0] valid;
      logic [7:0]   rdata;
      logic         nack;
      logic         tmo;
   } rsp_t;

   typedef struct {
      int           r;
      logic [6:0]   a;
      logic         rw;
      logic [7:0]   wd;
      int           rdy;
      int           dly;
      logic         nk;
      logic [7:0]   rd;
      logic [N-1:0] exp_grant;
   } vec_t;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   i2c_req_arbiter_if #(.NUM_REQ(N)) bus ();
   i2c_req_arbiter_if #(.NUM_REQ(N)) busb ();

   i2c_req_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .n_rst(n_rst), .bus_io(bus.slave));
   i2c_req_arbiter #(.NUM_REQ(N), .TIMEOUT(16), .GAP_CYCLES(5)) dut_t (
      .clk(clk), .n_rst(n_rst), .bus_io(busb.slave)
   );

   int   nerr = 0, nchk = 0, cyc = 0, g_cyc = 0, r_cyc = 0;
   bit   hold_req = 1'b0;
   logic [N-1:0] gq[$];
   rsp_t rspq[$];
   vec_t v[5];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every cycle of bus goes through here so no grant or response is missed.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (bus.req_grant != 0) begin
         g_cyc = cyc;
         if (gq.size() == 0) chk("grant_unexpected", 32'(bus.req_grant), 0);
         else chk("grant", 32'(bus.req_grant), 32'(gq.pop_front()));
         if (!hold_req) bus.req_valid = bus.req_valid & ~bus.req_grant;
      end
      if (bus.rsp_valid != 0) begin
         rsp_t e;
         r_cyc = cyc;
         if (rspq.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
         else begin
            e = rspq.pop_front();
            chk("rsp", 32'({bus.rsp_valid, bus.rsp_timeout, bus.rsp_nack, bus.rsp_rdata}),
                32'({e.valid, e.tmo, e.nack, e.rdata}));
         end
      end
   endtask

   task automatic rst_check(string tag);
      chk({tag, "_ctl"}, 32'({bus.req_grant, bus.rsp_valid, bus.rsp_rdata, bus.rsp_nack,
                              bus.rsp_timeout, bus.m_start, bus.m_abort}), 0);
      chk({tag, "_cmd"}, 32'({bus.m_addr, bus.m_rw, bus.m_wdata}), 0);
   endtask

   task automatic issue(int r, logic [6:0] a, logic rw, logic [7:0] wd, logic [N-1:0] eg);
      bus.req_addr[r*7 +: 7]  = a;
      bus.req_wdata[r*8 +: 8] = wd;
      bus.req_rw[r]           = rw;
      bus.req_valid[r]        = 1'b1;
      gq.push_back(eg);
   endtask

   // Plays the I2C master: accept after rdy stall cycles, finish dly cycles after accept.
   task automatic serve(logic [6:0] a, logic rw, logic [7:0] wd, int rdy, int dly,
                        logic nk, logic [7:0] rd, logic [N-1:0] ev);
      bit ok = 1'b1;
      rsp_t e;
      for (int i = 0; i < 100 && !bus.m_start; i++) tick();
      chk("m_start_seen", 32'(bus.m_start), 1);
      if (!bus.m_start) return;
      chk("cmd", 32'({bus.m_addr, bus.m_rw, bus.m_wdata}), 32'({a, rw, wd}));
      for (int i = 0; i < rdy; i++) begin
         if (!hold_req) begin
            bus.req_addr  = ~bus.req_addr;
            bus.req_wdata = ~bus.req_wdata;
            bus.req_rw    = ~bus.req_rw;
         end
         tick();
         ok &= bus.m_start && ({bus.m_addr, bus.m_rw, bus.m_wdata} == {a, rw, wd});
      end
      if (rdy > 0) chk("stall_hold", 32'(ok), 1);
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      chk("start_drop", 32'(bus.m_start), 0);
      repeat (dly - 1) tick();
      e.valid = ev; e.rdata = rd; e.nack = nk; e.tmo = 1'b0;
      rspq.push_back(e);
      bus.m_done = 1'b1; bus.m_nack = nk; bus.m_rdata = rd;
      tick();
      bus.m_done = 1'b0; bus.m_nack = 1'b0; bus.m_rdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
      $fatal(1);
   end

   initial begin
      int last_r, k;
      bus.req_valid = '0; bus.req_addr = '0; bus.req_rw = '0; bus.req_wdata = '0;
      bus.m_ready = 1'b0; bus.m_done = 1'b0; bus.m_nack = 1'b0; bus.m_rdata = '0;
      busb.req_valid = '0; busb.req_addr = '0; busb.req_rw = '0; busb.req_wdata = '0;
      busb.m_ready = 1'b0; busb.m_done = 1'b0; busb.m_nack = 1'b0; busb.m_rdata = '0;
      v[0] = '{0, 7'h54, 1'b0, 8'hA5, 1,  20, 1'b0, 8'h00, 4'b0001};
      v[1] = '{2, 7'h29, 1'b1, 8'h00, 1,  5,  1'b1, 8'h3C, 4'b0100};
      v[2] = '{1, 7'h7F, 1'b0, 8'h5A, 0,  1,  1'b0, 8'h00, 4'b0010};
      v[3] = '{3, 7'h00, 1'b1, 8'hFF, 50, 3,  1'b0, 8'hC3, 4'b1000};
      v[4] = '{3, 7'h3B, 1'b0, 8'h81, 2,  4,  1'b1, 8'hE7, 4'b1000};

      repeat (3) @(negedge clk);
      rst_check("reset");
      n_rst = 1'b1;
      tick();

      last_r = 0;
      for (int i = 0; i < 5; i++) begin
         last_r = r_cyc;
         issue(v[i].r, v[i].a, v[i].rw, v[i].wd, v[i].exp_grant);
         serve(v[i].a, v[i].rw, v[i].wd, v[i].rdy, v[i].dly, v[i].nk, v[i].rd, v[i].exp_grant);
         if (i > 0) chk("gap_to_grant", 32'(g_cyc - last_r), 7);
      end
      tick();
      chk("rsp_hold", 32'({bus.rsp_nack, bus.rsp_rdata}), 32'({1'b1, 8'hE7}));
      bus.m_done = 1'b1; bus.m_ready = 1'b1; bus.m_rdata = 8'hEE;
      tick();
      bus.m_done = 1'b0; bus.m_ready = 1'b0; bus.m_rdata = '0;
      chk("no_start_in_gap", 32'(bus.m_start), 0);
      repeat (8) tick();

      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      hold_req = 1'b1;
      for (int r = 0; r < N; r++) issue(r, 7'h10 + 7'(r), r[0], 8'hA0 + 8'(r), '0);
      gq.delete();
      for (int i = 0; i < 5; i++) begin
         int r;
         r = i % N;
         gq.push_back(N'(1) << r);
         serve(7'h10 + 7'(r), r[0], 8'hA0 + 8'(r), 0, 2, 1'b0, 8'(i), N'(1) << r);
      end
      bus.req_valid = '0;
      hold_req = 1'b0;
      repeat (8) tick();

      issue(1, 7'h22, 1'b0, 8'h44, 4'b0010);
      for (int i = 0; i < 20 && !bus.m_start; i++) tick();
      chk("wait_start", 32'(bus.m_start), 1);
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      repeat (3) tick();
      #2 n_rst = 1'b0;
      #1 rst_check("mid_wait_reset");
      tick();
      n_rst = 1'b1;
      bus.req_valid = '1;
      bus.req_addr[6:0] = 7'h33; bus.req_rw[0] = 1'b1; bus.req_wdata[7:0] = 8'h00;
      gq.push_back(4'b0001);
      serve(7'h33, 1'b1, 8'h00, 0, 2, 1'b0, 8'h99, 4'b0001);
      bus.req_valid = '0;
      repeat (8) tick();

      busb.req_addr[6:0] = 7'h0A;
      busb.req_valid = 4'b0001;
      for (k = 0; k < 20 && !busb.m_start; k++) tick();
      chk("t_start", 32'(busb.m_start), 1);
      busb.req_valid = '0;
      busb.m_ready = 1'b1;
      tick();
      busb.m_ready = 1'b0;
      for (k = 1; k <= 40; k++) begin
         tick();
         if (busb.m_abort) break;
      end
      chk("abort_cycle", 32'(k), 16);
      chk("t_rsp", 32'({busb.rsp_valid, busb.rsp_timeout, busb.rsp_nack, busb.rsp_rdata}),
          32'({4'b0001, 1'b1, 1'b0, 8'h00}));
      tick();
      chk("abort_pulse", 32'({busb.m_abort, busb.rsp_valid}), 0);

      busb.req_valid = 4'b0001;
      for (k = 0; k < 20 && !busb.m_start; k++) tick();
      chk("t2_start", 32'(busb.m_start), 1);
      busb.req_valid = '0;
      busb.m_ready = 1'b1;
      tick();
      busb.m_ready = 1'b0;
      repeat (15) tick();
      busb.m_done = 1'b1; busb.m_rdata = 8'h5A;
      tick();
      busb.m_done = 1'b0; busb.m_rdata = '0;
      chk("done_wins", 32'({busb.m_abort, busb.rsp_valid, busb.rsp_timeout, busb.rsp_rdata}),
          32'({1'b0, 4'b0001, 1'b0, 8'h5A}));

      repeat (8) tick();
      chk("queues_empty", 32'(gq.size() + rspq.size()), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
